// File: rtl/seq_alu.sv
// Sequential MIPS-style ALU: single-cycle logic/shift/compare ops plus
// iterative one-bit-per-clock multiply and divide writing the HI/LO pair.
module seq_alu #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       func,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [SHW-1:0]   shamt,
    output logic             out_valid,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [5:0] F_SLL   = 6'b000000;
    localparam logic [5:0] F_SRL   = 6'b000010;
    localparam logic [5:0] F_SRA   = 6'b000011;
    localparam logic [5:0] F_SLLV  = 6'b000100;
    localparam logic [5:0] F_SRLV  = 6'b000110;
    localparam logic [5:0] F_SRAV  = 6'b000111;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_ADDU  = 6'b100001;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_SUBU  = 6'b100011;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_XOR   = 6'b100110;
    localparam logic [5:0] F_NOR   = 6'b100111;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_SLTU  = 6'b101011;
    localparam logic [5:0] F_BEQ   = 6'b111000;
    localparam logic [5:0] F_BNE   = 6'b111001;
    localparam logic [5:0] F_BLEZ  = 6'b111010;
    localparam logic [5:0] F_BGTZ  = 6'b111011;
    localparam logic [5:0] F_BGEZ  = 6'b111100;
    localparam logic [5:0] F_LUI   = 6'b111101;

    localparam logic [SHW-1:0] CNT_ONE  = SHW'(1);
    localparam logic [SHW-1:0] CNT_LOAD = SHW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t state_reg, state_next;

    logic [SHW-1:0]       cnt_reg;
    logic [2*WIDTH-1:0]   work_reg;
    logic [WIDTH-1:0]     mcand_reg;
    logic [WIDTH-1:0]     dividend_reg;
    logic                 neg_q_reg;
    logic                 neg_r_reg;
    logic                 div0_reg;
    logic [WIDTH-1:0]     out_reg;
    logic                 zero_reg;
    logic [WIDTH-1:0]     hi_reg;
    logic [WIDTH-1:0]     lo_reg;

    logic accept;
    logic is_mul, is_div, is_signed;
    logic a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;

    assign accept    = in_valid && in_ready;
    assign is_mul    = (func == F_MULT) || (func == F_MULTU);
    assign is_div    = (func == F_DIV)  || (func == F_DIVU);
    assign is_signed = (func == F_MULT) || (func == F_DIV);
    assign a_neg     = is_signed && a[WIDTH-1];
    assign b_neg     = is_signed && b[WIDTH-1];
    assign a_mag     = a_neg ? -a : a;
    assign b_mag     = b_neg ? -b : b;

    // Shift-add multiply on magnitudes: work = {partial product, remaining multiplier}.
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_step;
    logic [2*WIDTH-1:0]   product;

    assign mul_sum  = {1'b0, work_reg[2*WIDTH-1:WIDTH]}
                    + {1'b0, (work_reg[0] ? mcand_reg : {WIDTH{1'b0}})};
    assign mul_step = {mul_sum, work_reg[WIDTH-1:1]};
    assign product  = neg_q_reg ? -mul_step : mul_step;

    // Restoring divide on magnitudes: work = {remainder, dividend shifting into quotient}.
    logic [WIDTH:0]       div_trial;
    logic [WIDTH:0]       div_diff;
    logic [WIDTH-1:0]     div_rem;
    logic [2*WIDTH-1:0]   div_step;
    logic [WIDTH-1:0]     quo_mag, rem_mag;
    logic [WIDTH-1:0]     div_lo, div_hi;

    assign div_trial = work_reg[2*WIDTH-1:WIDTH-1];
    assign div_diff  = div_trial - {1'b0, mcand_reg};
    assign div_rem   = div_diff[WIDTH] ? div_trial[WIDTH-1:0] : div_diff[WIDTH-1:0];
    assign div_step  = {div_rem, work_reg[WIDTH-2:0], ~div_diff[WIDTH]};
    assign quo_mag   = div_step[WIDTH-1:0];
    assign rem_mag   = div_step[2*WIDTH-1:WIDTH];
    assign div_lo    = div0_reg ? {WIDTH{1'b1}} : (neg_q_reg ? -quo_mag : quo_mag);
    assign div_hi    = div0_reg ? dividend_reg : (neg_r_reg ? -rem_mag : rem_mag);

    // Single-cycle result; undefined codes fall through to out = 0, zero = 1.
    logic [WIDTH-1:0] alu_out;
    logic             alu_zero;
    logic             is_branch;
    logic             branch_cond;

    always_comb begin
        alu_out     = '0;
        is_branch   = 1'b0;
        branch_cond = 1'b0;
        case (func)
            F_SLL:   alu_out = b << shamt;
            F_SRL:   alu_out = b >> shamt;
            F_SRA:   alu_out = $signed(b) >>> shamt;
            F_SLLV:  alu_out = b << a[SHW-1:0];
            F_SRLV:  alu_out = b >> a[SHW-1:0];
            F_SRAV:  alu_out = $signed(b) >>> a[SHW-1:0];
            F_MFHI:  alu_out = hi_reg;
            F_MFLO:  alu_out = lo_reg;
            F_ADDU:  alu_out = a + b;
            F_SUB:   alu_out = a - b;
            F_SUBU:  alu_out = a - b;
            F_AND:   alu_out = a & b;
            F_OR:    alu_out = a | b;
            F_XOR:   alu_out = a ^ b;
            F_NOR:   alu_out = ~(a | b);
            F_SLT:   alu_out = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            F_SLTU:  alu_out = {{(WIDTH-1){1'b0}}, (a < b)};
            F_LUI:   alu_out = {b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
            F_BEQ: begin
                is_branch   = 1'b1;
                branch_cond = (a == b);
            end
            F_BNE: begin
                is_branch   = 1'b1;
                branch_cond = (a != b);
            end
            F_BLEZ: begin
                is_branch   = 1'b1;
                branch_cond = a[WIDTH-1] || (a == '0);
            end
            F_BGTZ: begin
                is_branch   = 1'b1;
                branch_cond = !a[WIDTH-1] && (a != '0);
            end
            F_BGEZ: begin
                is_branch   = 1'b1;
                branch_cond = !a[WIDTH-1];
            end
            default: alu_out = '0;
        endcase
        alu_zero = is_branch ? branch_cond : (alu_out == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    if (is_mul) begin
                        state_next = MUL;
                    end else if (is_div) begin
                        state_next = DIV;
                    end else begin
                        state_next = DONE;
                    end
                end
            end
            MUL:     if (cnt_reg == '0) state_next = DONE;
            DIV:     if (cnt_reg == '0) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg      <= '0;
            work_reg     <= '0;
            mcand_reg    <= '0;
            dividend_reg <= '0;
            neg_q_reg    <= 1'b0;
            neg_r_reg    <= 1'b0;
            div0_reg     <= 1'b0;
            out_reg      <= '0;
            zero_reg     <= 1'b0;
            hi_reg       <= '0;
            lo_reg       <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        if (is_mul) begin
                            work_reg  <= {{WIDTH{1'b0}}, b_mag};
                            mcand_reg <= a_mag;
                            neg_q_reg <= a_neg ^ b_neg;
                            cnt_reg   <= CNT_LOAD;
                        end else if (is_div) begin
                            work_reg     <= {{WIDTH{1'b0}}, a_mag};
                            mcand_reg    <= b_mag;
                            neg_q_reg    <= a_neg ^ b_neg;
                            neg_r_reg    <= a_neg;
                            div0_reg     <= (b == '0);
                            dividend_reg <= a;
                            cnt_reg      <= CNT_LOAD;
                        end else begin
                            out_reg  <= alu_out;
                            zero_reg <= alu_zero;
                        end
                    end
                end
                MUL: begin
                    work_reg <= mul_step;
                    if (cnt_reg == '0) begin
                        hi_reg   <= product[2*WIDTH-1:WIDTH];
                        lo_reg   <= product[WIDTH-1:0];
                        out_reg  <= product[WIDTH-1:0];
                        zero_reg <= (product[WIDTH-1:0] == '0);
                    end else begin
                        cnt_reg <= cnt_reg - CNT_ONE;
                    end
                end
                DIV: begin
                    work_reg <= div_step;
                    if (cnt_reg == '0) begin
                        hi_reg   <= div_hi;
                        lo_reg   <= div_lo;
                        out_reg  <= div_lo;
                        zero_reg <= (div_lo == '0);
                    end else begin
                        cnt_reg <= cnt_reg - CNT_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign out       = out_reg;
    assign zero      = zero_reg;
    assign hi        = hi_reg;
    assign lo        = lo_reg;

endmodule
